// File: rtl/axi4_lite_ram_slave.sv
// ============================================================================
// Module      : axi4_lite_ram_slave
// Description : AXI4-Lite slave with an integrated word-addressed RAM.
//               Read and write channels run as independent state machines.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi4_lite_ram_slave #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_WIDTH-1:0]     AWADDR,
  input  logic                      AWVALID,
  output logic                      AWREADY,
  input  logic [DATA_WIDTH-1:0]     WDATA,
  input  logic [DATA_WIDTH/8-1:0]   WSTRB,
  input  logic                      WVALID,
  output logic                      WREADY,
  output logic [1:0]                BRESP,
  output logic                      BVALID,
  input  logic                      BREADY,
  input  logic [ADDR_WIDTH-1:0]     ARADDR,
  input  logic                      ARVALID,
  output logic                      ARREADY,
  output logic [DATA_WIDTH-1:0]     RDATA,
  output logic [1:0]                RRESP,
  output logic                      RVALID,
  input  logic                      RREADY
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_WIDTH - OFF_W;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W:0] DEPTH_L     = (IDX_W + 1)'(DEPTH);
  localparam logic [1:0]     RESP_OKAY   = 2'b00;
  localparam logic [1:0]     RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_RESET = 2'd0, R_IDLE = 2'd1, R_DATA = 2'd2} r_state_t;
  typedef enum logic [1:0] {W_RESET = 2'd0, W_IDLE = 2'd1, W_RESP = 2'd2} w_state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
    return {1'b0, idx} < DEPTH_L;
  endfunction

  logic [IDX_W-1:0] ar_idx;
  logic [IDX_W-1:0] aw_idx;
  logic             unused_addr_bits;
  assign ar_idx           = ARADDR[ADDR_WIDTH-1:OFF_W];
  assign aw_idx           = AWADDR[ADDR_WIDTH-1:OFF_W];
  assign unused_addr_bits = ^{ARADDR[OFF_W-1:0], AWADDR[OFF_W-1:0]};

  // ---------------------------------------------------------------- read side
  r_state_t              r_state_q, r_state_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;

  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_RESET: begin
        r_state_d = R_IDLE;
        arready_d = 1'b1;
      end
      R_IDLE: begin
        if (ARVALID) begin
          r_state_d = R_DATA;
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rdata_d   = idx_ok(ar_idx) ? mem[ar_idx[MEM_AW-1:0]] : '0;
          rresp_d   = idx_ok(ar_idx) ? RESP_OKAY : RESP_SLVERR;
        end
      end
      R_DATA: begin
        if (RREADY) begin
          r_state_d = R_IDLE;
          arready_d = 1'b1;
          rvalid_d  = 1'b0;
        end
      end
      default: begin
        r_state_d = R_RESET;
        arready_d = 1'b0;
        rvalid_d  = 1'b0;
        rdata_d   = '0;
        rresp_d   = RESP_OKAY;
      end
    endcase
    if (rst) begin
      r_state_d = R_RESET;
      arready_d = 1'b0;
      rvalid_d  = 1'b0;
      rdata_d   = '0;
      rresp_d   = RESP_OKAY;
    end
  end

  always_ff @(posedge clk) begin
    r_state_q <= r_state_d;
    arready_q <= arready_d;
    rvalid_q  <= rvalid_d;
    rdata_q   <= rdata_d;
    rresp_q   <= rresp_d;
  end

  // --------------------------------------------------------------- write side
  w_state_t              w_state_q, w_state_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  aw_held_q, aw_held_d;
  logic                  w_held_q, w_held_d;
  logic [IDX_W-1:0]      awidx_q, awidx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;

  logic                  aw_hs, w_hs;
  logic [IDX_W-1:0]      cur_idx;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [STRB_W-1:0]     mem_wstrb;

  assign aw_hs     = AWVALID && awready_q;
  assign w_hs      = WVALID && wready_q;
  // A payload arriving on the commit edge is used directly, not via its holding register.
  assign cur_idx   = aw_held_q ? awidx_q : aw_idx;
  assign mem_wdata = w_held_q ? wdata_q : WDATA;
  assign mem_wstrb = w_held_q ? wstrb_q : WSTRB;

  always_comb begin
    w_state_d = w_state_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awidx_d   = awidx_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    mem_we    = 1'b0;
    case (w_state_q)
      W_RESET: begin
        w_state_d = W_IDLE;
        awready_d = 1'b1;
        wready_d  = 1'b1;
      end
      W_IDLE: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          awidx_d   = aw_idx;
          awready_d = 1'b0;
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = WDATA;
          wstrb_d  = WSTRB;
          wready_d = 1'b0;
        end
        if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
          w_state_d = W_RESP;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          bvalid_d  = 1'b1;
          bresp_d   = idx_ok(cur_idx) ? RESP_OKAY : RESP_SLVERR;
          mem_we    = idx_ok(cur_idx);
        end
      end
      W_RESP: begin
        if (BREADY) begin
          w_state_d = W_IDLE;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          bvalid_d  = 1'b0;
        end
      end
      default: begin
        w_state_d = W_RESET;
        awready_d = 1'b0;
        wready_d  = 1'b0;
        bvalid_d  = 1'b0;
        bresp_d   = RESP_OKAY;
        aw_held_d = 1'b0;
        w_held_d  = 1'b0;
      end
    endcase
    if (rst) begin
      w_state_d = W_RESET;
      awready_d = 1'b0;
      wready_d  = 1'b0;
      bvalid_d  = 1'b0;
      bresp_d   = RESP_OKAY;
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      mem_we    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    w_state_q <= w_state_d;
    awready_q <= awready_d;
    wready_q  <= wready_d;
    bvalid_q  <= bvalid_d;
    bresp_q   <= bresp_d;
    aw_held_q <= aw_held_d;
    w_held_q  <= w_held_d;
    awidx_q   <= awidx_d;
    wdata_q   <= wdata_d;
    wstrb_q   <= wstrb_d;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (mem_wstrb[i]) mem[cur_idx[MEM_AW-1:0]][i*8 +: 8] <= mem_wdata[i*8 +: 8];
      end
    end
  end

  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;
  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;

endmodule

`default_nettype wire

// File: tb/tb_axi4_lite_ram_slave.sv
// ============================================================================
// Module      : tb_axi4_lite_ram_slave
// Description : Randomised bench for axi4_lite_ram_slave against an array model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi4_lite_ram_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] AWADDR, ARADDR;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic [31:0] WDATA, RDATA;
  logic [3:0]  WSTRB;
  logic [1:0]  BRESP, RRESP;
  logic        ARVALID, ARREADY, RVALID, RREADY;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] model_mem [0:255];

  axi4_lite_ram_slave #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .DEPTH(256)) dut (
    .clk(clk), .rst(rst),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit in_range(input logic [11:0] addr);
    return addr[11:2] < 10'd256;
  endfunction

  function automatic void model_write(input logic [11:0] addr, input logic [31:0] data,
                                      input logic [3:0] strb);
    if (in_range(addr))
      for (int i = 0; i < 4; i++)
        if (strb[i]) model_mem[addr[9:2]][i*8 +: 8] = data[i*8 +: 8];
  endfunction

  task automatic axi_write(input logic [11:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           input int b_dly);
    int cyc = 0;
    bit aw_done = 0, w_done = 0, aw_now, w_now;
    logic [1:0] exp_resp;
    exp_resp = in_range(addr) ? 2'b00 : 2'b10;
    AWADDR = addr; WDATA = data; WSTRB = strb;
    while (!(aw_done && w_done) && cyc < 60) begin
      AWVALID = !aw_done && cyc >= aw_dly;
      WVALID  = !w_done && cyc >= w_dly;
      aw_now  = AWVALID && AWREADY;
      w_now   = WVALID && WREADY;
      @(posedge clk); #1; cyc++;
      aw_done |= aw_now;
      w_done  |= w_now;
      if (aw_now && !w_done) check("awready_drop", AWREADY, 0);
      if (w_now && !aw_done) check("wready_drop", WREADY, 0);
    end
    AWVALID = 0; WVALID = 0;
    check("write_handshake", aw_done && w_done, 1);
    if (aw_done && w_done) model_write(addr, data, strb);
    check("bvalid_latency", BVALID, 1);
    check("bresp", BRESP, exp_resp);
    repeat (b_dly) begin
      @(posedge clk); #1;
      check("bvalid_hold", {BVALID, BRESP}, {1'b1, exp_resp});
      check("aw_w_blocked", {AWREADY, WREADY}, 2'b00);
    end
    BREADY = 1;
    @(posedge clk); #1;
    BREADY = 0;
    check("bvalid_clear", BVALID, 0);
    check("aw_w_ready_again", {AWREADY, WREADY}, 2'b11);
  endtask

  task automatic axi_read(input logic [11:0] addr, input int ar_dly, input int r_dly,
                          output logic [31:0] data, output logic [1:0] resp);
    int cyc = 0;
    bit done = 0, now;
    logic [31:0] exp_d = 0;
    logic [1:0]  exp_r = 0;
    ARADDR = addr;
    while (!done && cyc < 60) begin
      ARVALID = cyc >= ar_dly;
      #1;
      now = ARVALID && ARREADY;
      // Snapshot after any same-timestep model update from a write on the previous edge.
      if (now) begin
        exp_d = in_range(addr) ? model_mem[addr[9:2]] : 32'h0;
        exp_r = in_range(addr) ? 2'b00 : 2'b10;
      end
      @(posedge clk); #1; cyc++;
      done = now;
    end
    ARVALID = 0;
    check("read_handshake", done, 1);
    check("rvalid_latency", RVALID, 1);
    check("rdata", RDATA, exp_d);
    check("rresp", RRESP, exp_r);
    data = RDATA; resp = RRESP;
    repeat (r_dly) begin
      @(posedge clk); #1;
      check("rvalid_hold", {RVALID, RRESP, RDATA}, {1'b1, exp_r, exp_d});
      check("ar_blocked", ARREADY, 0);
    end
    RREADY = 1;
    @(posedge clk); #1;
    RREADY = 0;
    check("rvalid_clear", RVALID, 0);
    check("arready_again", ARREADY, 1);
  endtask

  function automatic logic [11:0] rand_addr();
    int r = $urandom_range(0, 9);
    logic [9:0] idx;
    if (r < 7)       idx = 10'($urandom_range(0, 15));
    else if (r == 7) idx = 10'd255;
    else if (r == 8) idx = 10'd256;
    else             idx = 10'($urandom_range(257, 1023));
    return {idx, 2'($urandom_range(0, 3))};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, old;
    logic [1:0]  r;
    rst = 1; AWVALID = 0; WVALID = 0; ARVALID = 0; BREADY = 0; RREADY = 0;
    AWADDR = 0; ARADDR = 0; WDATA = 0; WSTRB = 0;

    repeat (3) begin
      @(posedge clk); #1;
      check("rst_outputs", {ARREADY, AWREADY, WREADY, RVALID, BVALID, BRESP, RRESP}, 0);
      check("rst_rdata", RDATA, 0);
    end
    rst = 0;
    @(posedge clk); #1;
    check("idle_readies", {ARREADY, AWREADY, WREADY, RVALID, BVALID}, 5'b11100);

    // Known contents for every word the random phase may touch.
    for (int i = 0; i < 16; i++) axi_write(12'(i * 4), $urandom, 4'hF, 0, 0, 0);
    axi_write(12'h3FC, $urandom, 4'hF, 0, 0, 0);

    axi_write(12'h010, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    axi_read(12'h010, 0, 0, d, r);
    check("wr_rd_data", d, 32'hDEADBEEF);

    axi_write(12'h010, 32'h000000AA, 4'h1, 3, 0, 0);
    axi_read(12'h010, 0, 0, d, r);
    check("strb_merge", d, 32'hDEADBEAA);

    axi_write(12'h010, 32'h12345678, 4'h0, 0, 2, 0);
    axi_read(12'h010, 0, 0, d, r);
    check("strb_zero", d, 32'hDEADBEAA);

    old = model_mem[0];
    axi_write(12'h400, 32'hCAFEF00D, 4'hF, 0, 0, 0);
    axi_read(12'h400, 0, 0, d, r);
    check("oor_resp", {r, d}, {2'b10, 32'h0});
    axi_read(12'h000, 0, 0, d, r);
    check("oor_no_alias", d, old);

    axi_write(12'h014, 32'h0BADCAFE, 4'hF, 1, 0, 5);
    axi_read(12'h014, 0, 5, d, r);

    old = model_mem[8];
    fork
      axi_write(12'h020, 32'h13579BDF, 4'hF, 0, 0, 0);
      axi_read(12'h020, 0, 0, d, r);
    join
    check("same_edge_old", d, old);
    axi_read(12'h020, 0, 0, d, r);
    check("later_new", d, 32'h13579BDF);

    AWADDR = 12'h030; WDATA = 32'hA5A5_5A5A; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
    @(posedge clk); #1;
    AWVALID = 0; WVALID = 0;
    model_write(12'h030, 32'hA5A5_5A5A, 4'hF);
    check("abort_bvalid_before", BVALID, 1);
    rst = 1;
    @(posedge clk); #1;
    check("abort_bvalid", {BVALID, AWREADY, WREADY}, 3'b000);
    rst = 0;
    @(posedge clk); #1;
    check("abort_idle", {BVALID, AWREADY, WREADY, ARREADY}, 4'b0111);
    axi_read(12'h030, 0, 0, d, r);

    for (int n = 0; n < 60; n++) begin
      logic [11:0] a, b;
      int op = $urandom_range(0, 2);
      a = rand_addr();
      b = ($urandom_range(0, 1) == 1) ? a : rand_addr();
      if (op == 0)
        axi_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 2));
      else if (op == 1)
        axi_read(a, $urandom_range(0, 2), $urandom_range(0, 2), d, r);
      else
        fork
          axi_write(a, $urandom, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
                    $urandom_range(0, 2));
          axi_read(b, $urandom_range(0, 2), $urandom_range(0, 2), d, r);
        join
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/axi4_lite_ram_slave.md
Name: axi4_lite_ram_slave

Overview:
- Parametrised AXI4-Lite slave with an integrated word-addressed RAM; next generation of the single-FSM AXI4-Lite handshake controller.
- Read and write channels run as independent FSMs, so a read and a write may be in flight at the same time.
- Adds AW/W acceptance in any order, WSTRB byte-lane writes, configurable data width and depth, and SLVERR responses for out-of-range addresses.
- Sits between the AXI4-Lite interconnect and local storage; it is the leaf target of a register or memory bus.

Parameters:
- ADDR_WIDTH, 12, byte-address width of AWADDR/ARADDR.
- DATA_WIDTH, 32, data bus width; must be 32 or 64.
- DEPTH, 256, number of DATA_WIDTH-bit words; must be ≤ 2^(ADDR_WIDTH - log2(DATA_WIDTH/8)).

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- AWADDR  in  ADDR_WIDTH  write address.
- AWVALID  in  1 / AWREADY  out  1  write-address handshake.
- WDATA  in  DATA_WIDTH  write data.
- WSTRB  in  DATA_WIDTH/8  byte-lane write enables.
- WVALID  in  1 / WREADY  out  1  write-data handshake.
- BRESP  out  2  write response.
- BVALID  out  1 / BREADY  in  1  write-response handshake.
- ARADDR  in  ADDR_WIDTH  read address.
- ARVALID  in  1 / ARREADY  out  1  read-address handshake.
- RDATA  out  DATA_WIDTH  read data.
- RRESP  out  2  read response.
- RVALID  out  1 / RREADY  in  1  read-data handshake.

Behaviour:
- Reset (clk, rst synchronous active-high):
  - Any edge with rst=1 puts both FSMs in RESET and clears the captured-address/data flags.
  - While in RESET all READY/VALID outputs are 0, and BRESP, RRESP and RDATA are 0.
  - rst aborts any transaction in progress, including one mid-handshake.
  - RAM contents are not cleared.
  - The first edge with rst=0 moves both FSMs to IDLE; the READY outputs rise in that following cycle.
- Address decode:
  - Word index = addr[ADDR_WIDTH-1 : log2(DATA_WIDTH/8)]; the low byte-offset bits are ignored.
  - Index ≥ DEPTH is out of range: the response is 2'b10 (SLVERR). Otherwise the response is 2'b00 (OKAY).
- Read FSM, states RESET → R_IDLE → R_DATA:
  - R_IDLE: ARREADY=1. On ARVALID at an edge, capture the word, RRESP and RDATA into registers (RDATA=0 if out of range) and move to R_DATA.
  - R_DATA: RVALID=1 and ARREADY=0. RDATA/RRESP hold stable until an edge with RREADY=1, then return to R_IDLE.
  - Latency: RVALID is high in the cycle after the AR handshake. Back-to-back reads are therefore at most 1 per 2 cycles.
- Write FSM, states RESET → W_IDLE → W_RESP:
  - W_IDLE: AWREADY=1 while no address is held; WREADY=1 while no data is held.
  - AW and W may complete in either order or on the same edge.
  - Each handshake latches its payload and sets a held flag, and that channel's READY drops.
  - On the edge where both are held (or both arrive together), the in-range write commits and the FSM moves to W_RESP.
  - The commit writes only the byte lanes with WSTRB[i]=1; WSTRB=0 commits nothing but still responds OKAY.
  - An out-of-range write is suppressed and answered with SLVERR.
  - W_RESP: BVALID=1, both write READYs are 0, and BRESP is held until an edge with BREADY=1. That edge clears the held flags and returns to W_IDLE.
  - Latency: BVALID is high in the cycle after the final handshake.
- Simultaneous read and write:
  - The two FSMs are fully independent.
  - If an AR handshake and a write commit to the same word occur on the same edge, the read returns the pre-write data.
  - A read accepted on any later edge sees the new data.
- Unused or illegal FSM encodings go to RESET on the next edge.
- A VALID that drops without a handshake has no effect.

Test Plan:
- Reset and idle: hold rst for 3 cycles, then release. Required: all VALIDs 0 during reset; ARREADY=AWREADY=WREADY=1 from the second cycle after release.
- Write then read (DATA_WIDTH=32): AW=0x010 and W=0xDEADBEEF with WSTRB=0xF on the same edge. Required: BVALID the next cycle, BRESP=00. Then AR=0x010 → RVALID the next cycle, RDATA=0xDEADBEEF, RRESP=00.
- Order and strobes:
  - W first (0x000000AA, WSTRB=0x1), AW=0x010 three cycles later. Required: WREADY drops after the W handshake; BVALID the cycle after the AW handshake.
  - A following read of 0x010 → 0xDEADBEAA.
- Out of range (DEPTH=256): write 0x400, then read 0x400. Required: BRESP=10, RRESP=10, RDATA=0, and no RAM word modified.
- Backpressure: hold RREADY=0 and BREADY=0 for 5 cycles. Required: RVALID/BVALID and their data stay stable, and no new AR/AW is accepted until the respective READY handshake.
- Concurrency and abort:
  - AR and a write commit to the same word on the same edge. Required: the read returns the old value.
  - Assert rst while in W_RESP. Required: BVALID=0 on the next edge and the FSM back in IDLE after release.
